console_ctrl: RTL and testbench
===============================

CONSOLE_CTRL -- requirements
Module: console_ctrl

Interface
REQ-001 Parameter COLS, default 70, meaning text columns per row (x range 0..COLS-1).
REQ-002 Parameter ROWS, default 32, meaning text rows (y range 0..ROWS-1).
REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 key_rd  output  1  pop request to the keyboard FIFO, one-cycle pulse.
REQ-006 key_data  input  8  FIFO read data, registered by the FIFO on the edge where key_rd=1; 0x00 means empty.
REQ-007 vga_we  output  1  text-buffer write enable, one cycle per write.
REQ-008 vga_addr  output  32  text-buffer write address: bits[11:0]={x[6:0],y[4:0]}, bits[31:12]=0.
REQ-009 vga_char  output  8  character written to the text buffer.
REQ-010 cur_x  output  7  current cursor column.
REQ-011 cur_y  output  5  current cursor row.
REQ-012 busy  output  1  high in any state other than POLL.

Function
REQ-013 The FSM SHALL have states INIT, POLL, CAPT, WRITE, CLEAR.
- POLL: key_rd=1 for one cycle, go to CAPT.
- CAPT: sample key_data and decode; 0x00 goes to POLL; others go to WRITE or CLEAR per REQ-014..REQ-017.
REQ-014 Printable (0x20..0x7E) SHALL cause WRITE: vga_we=1, vga_char=code, address=(cur_x,cur_y); then cur_x+1.
- If cur_x was COLS-1: cur_x=0, cur_y advances (REQ-017), go to CLEAR.
- Otherwise return to POLL.
REQ-015 0x0A or 0x0D SHALL set cur_x=0, advance cur_y (REQ-017) and go to CLEAR, with no character write.
REQ-016 0x08 (backspace):
- cur_x>0: cur_x-1, then WRITE of 0x20 at the new position, then POLL.
- cur_x=0: no-op, return to POLL (no reverse row wrap).
REQ-017 Row advance SHALL be cur_y+1, wrapping ROWS-1 -> 0.
REQ-018 All other codes (0x01..0x07, 0x09, 0x0B, 0x0C, 0x0E..0x1F, 0x7F..0xFF) SHALL be discarded with no write and no cursor change.
REQ-019 CLEAR SHALL issue COLS consecutive writes of 0x20 at (0..COLS-1, cur_y), one per cycle, then go to POLL; key_rd=0 throughout.
REQ-020 Latency: printable char SHALL be written in the 2nd cycle after the key_rd pulse; minimum 3 cycles per character, POLL->CAPT->WRITE.
REQ-021 vga_we SHALL never be asserted in POLL or CAPT; key_rd SHALL never be asserted outside POLL.
REQ-022 cur_x/cur_y SHALL never exceed COLS-1/ROWS-1.

Reset
REQ-023 On rst=1 at a clock edge, SHALL set key_rd=0, vga_we=0, vga_addr=0, vga_char=0, cur_x=0, cur_y=0, clear the internal clear counter, and enter INIT (or POLL per REQ-025).
REQ-024 rst asserted mid-CLEAR or mid-WRITE SHALL abort at once with no further writes; the partially cleared row is left as is.

Configuration
REQ-025 Macro CONSOLE_INIT_CLEAR_EN:
- Defined: after reset, INIT writes 0x20 to all COLS*ROWS cells (y outer 0..ROWS-1, x inner 0..COLS-1), one per cycle, with busy=1 and key_rd=0, then goes to POLL.
- Undefined: INIT is absent and reset enters POLL directly.

Verification
REQ-026 Reset, FIFO returns 0x41 then 0x00 -> exactly one write, 0x41 at {x=0,y=0}, 2 cycles after key_rd; cur_x=1.
REQ-027 Feed 70 x 0x61 -> last write at x=69,y=0; then 70 writes of 0x20 to row 1; cur_x=0, cur_y=1.
REQ-028 cur_y=31, feed 0x0D -> cur_y=0, cur_x=0; row 0 cleared by 70 writes; no write to row 31.
REQ-029 cur_x=0 then 0x08 -> no write; cur_x=3 then 0x08 -> 0x20 written at x=2, cur_x=2.
REQ-030 0x09 and 0x7F fed -> no vga_we, cursor unchanged.
REQ-031 rst pulsed during CLEAR at column 10 -> vga_we low the next cycle, cursor (0,0); with CONSOLE_INIT_CLEAR_EN, 2240 writes before the first key_rd.

Source files
------------

// File: rtl/console_ctrl.sv
// console_ctrl: keyboard-FIFO to text-buffer console with cursor, newline, backspace and row clear.
// Define CONSOLE_INIT_CLEAR_EN to blank the whole screen after reset before polling starts.
module console_ctrl #(
  parameter int COLS = 70,
  parameter int ROWS = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic        key_rd,
  input  logic [7:0]  key_data,
  output logic        vga_we,
  output logic [31:0] vga_addr,
  output logic [7:0]  vga_char,
  output logic [6:0]  cur_x,
  output logic [4:0]  cur_y,
  output logic        busy
);
  localparam logic [6:0] XMAX = 7'(COLS - 1);
  localparam logic [4:0] YMAX = 5'(ROWS - 1);
  localparam logic [6:0] NCOL = 7'(COLS);
  typedef enum logic [2:0] {
    POLL, CAPT, WRITE, CLEAR
`ifdef CONSOLE_INIT_CLEAR_EN
    , INIT
`endif
  } state_t;
`ifdef CONSOLE_INIT_CLEAR_EN
  localparam state_t RST_STATE = INIT;
  logic [4:0] iy_q;
  logic       idone_q;
`else
  localparam state_t RST_STATE = POLL;
`endif
  state_t      state_q;
  logic        key_rd_q, we_q, bs_q;
  logic [11:0] addr_q;
  logic [7:0]  char_q;
  logic [6:0]  cur_x_q, clr_q;
  logic [4:0]  cur_y_q, y_nx;
  logic        printable, newline;
  assign y_nx      = cur_y_q == YMAX ? 5'd0 : cur_y_q + 5'd1;
  assign printable = key_data >= 8'h20 && key_data <= 8'h7E;
  assign newline   = key_data == 8'h0A || key_data == 8'h0D;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RST_STATE;
      key_rd_q <= 1'b0;
      we_q     <= 1'b0;
      bs_q     <= 1'b0;
      addr_q   <= '0;
      char_q   <= '0;
      cur_x_q  <= '0;
      cur_y_q  <= '0;
      clr_q    <= '0;
`ifdef CONSOLE_INIT_CLEAR_EN
      iy_q     <= '0;
      idone_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        // First POLL cycle after reset only arms key_rd, so the pop always precedes CAPT.
        POLL: begin
          key_rd_q <= ~key_rd_q;
          if (key_rd_q) state_q <= CAPT;
        end
        CAPT: begin
          if (printable) begin
            state_q <= WRITE;
            we_q    <= 1'b1;
            char_q  <= key_data;
            addr_q  <= {cur_x_q, cur_y_q};
            bs_q    <= 1'b0;
          end else if (newline) begin
            state_q <= CLEAR;
            cur_x_q <= '0;
            cur_y_q <= y_nx;
            we_q    <= 1'b1;
            char_q  <= 8'h20;
            addr_q  <= {7'd0, y_nx};
            clr_q   <= 7'd1;
          end else if (key_data == 8'h08 && cur_x_q != 7'd0) begin
            state_q <= WRITE;
            cur_x_q <= cur_x_q - 7'd1;
            we_q    <= 1'b1;
            char_q  <= 8'h20;
            addr_q  <= {cur_x_q - 7'd1, cur_y_q};
            bs_q    <= 1'b1;
          end else begin
            state_q  <= POLL;
            key_rd_q <= 1'b1;
          end
        end
        WRITE: begin
          if (!bs_q && cur_x_q == XMAX) begin
            state_q <= CLEAR;
            cur_x_q <= '0;
            cur_y_q <= y_nx;
            char_q  <= 8'h20;
            addr_q  <= {7'd0, y_nx};
            clr_q   <= 7'd1;
          end else begin
            state_q  <= POLL;
            key_rd_q <= 1'b1;
            we_q     <= 1'b0;
            if (!bs_q) cur_x_q <= cur_x_q + 7'd1;
          end
        end
        CLEAR: begin
          if (clr_q == NCOL) begin
            state_q  <= POLL;
            key_rd_q <= 1'b1;
            we_q     <= 1'b0;
          end else begin
            addr_q <= {clr_q, cur_y_q};
            clr_q  <= clr_q + 7'd1;
          end
        end
`ifdef CONSOLE_INIT_CLEAR_EN
        INIT: begin
          if (idone_q) begin
            state_q  <= POLL;
            key_rd_q <= 1'b1;
            we_q     <= 1'b0;
          end else begin
            we_q   <= 1'b1;
            char_q <= 8'h20;
            addr_q <= {clr_q, iy_q};
            clr_q  <= clr_q == XMAX ? 7'd0 : clr_q + 7'd1;
            if (clr_q == XMAX && iy_q == YMAX) idone_q <= 1'b1;
            else if (clr_q == XMAX) iy_q <= iy_q + 5'd1;
          end
        end
`endif
        default: begin
          state_q  <= POLL;
          key_rd_q <= 1'b0;
          we_q     <= 1'b0;
        end
      endcase
    end
  end
  assign key_rd   = key_rd_q;
  assign vga_we   = we_q;
  assign vga_addr = {20'd0, addr_q};
  assign vga_char = char_q;
  assign cur_x    = cur_x_q;
  assign cur_y    = cur_y_q;
  assign busy     = state_q != POLL;
endmodule

// File: tb/tb_console_ctrl.sv
// tb_console_ctrl: scoreboard bench for console_ctrl; FIFO model feeds keys, monitor checks every write.
module tb_console_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic        key_rd, vga_we, busy;
  logic [7:0]  key_data = 8'h00, vga_char;
  logic [31:0] vga_addr;
  logic [6:0]  cur_x;
  logic [4:0]  cur_y;
  typedef struct {logic [11:0] a; logic [7:0] c; bit lat;} ent_t;
  ent_t       sb[$];
  ent_t       me;
  logic [7:0] fifo[$];
  int tests = 0, fails = 0, cyc = 0, kr_cyc = 0;

  console_ctrl dut (
    .clk(clk), .rst(rst), .key_rd(key_rd), .key_data(key_data), .vga_we(vga_we),
    .vga_addr(vga_addr), .vga_char(vga_char), .cur_x(cur_x), .cur_y(cur_y), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (key_rd) begin
      if (fifo.size() != 0) key_data <= fifo.pop_front();
      else key_data <= 8'h00;
    end
  end

  task automatic chk(string n, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", n, act, exp);
    end
  endtask

  function automatic void expw(int x, int y, logic [7:0] c, bit lat);
    ent_t e;
    e.a = {7'(x), 5'(y)};
    e.c = c;
    e.lat = lat;
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (key_rd) begin
      kr_cyc = cyc;
      chk("rd_we_exclusive", vga_we, 0);
    end
    if (vga_we) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr 0x%0h char 0x%0h, no write expected", vga_addr, vga_char);
      end else begin
        me = sb.pop_front();
        chk("write_addr", vga_addr, {20'd0, me.a});
        chk("write_char", vga_char, me.c);
        if (me.lat) chk("write_latency", cyc - kr_cyc, 2);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (fifo.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 20000);
    if (n >= 20000) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: busy %0b fifo %0d, expected idle", busy, fifo.size());
    end
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_key_rd", key_rd, 0);
    chk("rst_vga_we", vga_we, 0);
    chk("rst_vga_addr", vga_addr, 0);
    chk("rst_vga_char", vga_char, 0);
    chk("rst_cur_x", cur_x, 0);
    chk("rst_cur_y", cur_y, 0);
    rst = 1'b0;
`ifdef CONSOLE_INIT_CLEAR_EN
    begin
      int n = 0;
      for (int y = 0; y < 32; y++) for (int x = 0; x < 70; x++) expw(x, y, 8'h20, 1'b0);
      while (!key_rd && n < 5000) begin
        @(negedge clk);
        n++;
      end
      chk("init_rd_seen", key_rd, 1);
      chk("init_writes_before_rd", sb.size(), 0);
    end
`endif
  endtask

  initial begin
    do_reset();
    fifo.push_back(8'h41);
    fifo.push_back(8'h00);
    expw(0, 0, 8'h41, 1'b1);
    wait_idle();
    chk("single_cur_x", cur_x, 1);
    chk("single_cur_y", cur_y, 0);

    do_reset();
    for (int i = 0; i < 70; i++) begin
      fifo.push_back(8'h61);
      expw(i, 0, 8'h61, 1'b1);
    end
    for (int i = 0; i < 70; i++) expw(i, 1, 8'h20, 1'b0);
    wait_idle();
    chk("wrap_cur_x", cur_x, 0);
    chk("wrap_cur_y", cur_y, 1);

    for (int n = 0; n < 30; n++) begin
      fifo.push_back(8'h0A);
      for (int i = 0; i < 70; i++) expw(i, n + 2, 8'h20, 1'b0);
    end
    wait_idle();
    chk("lf_cur_y", cur_y, 31);
    fifo.push_back(8'h0D);
    for (int i = 0; i < 70; i++) expw(i, 0, 8'h20, 1'b0);
    wait_idle();
    chk("cr_wrap_cur_x", cur_x, 0);
    chk("cr_wrap_cur_y", cur_y, 0);

    fifo.push_back(8'h08);
    wait_idle();
    chk("bs_at_0_cur_x", cur_x, 0);
    fifo.push_back(8'h78);
    fifo.push_back(8'h79);
    fifo.push_back(8'h7A);
    expw(0, 0, 8'h78, 1'b1);
    expw(1, 0, 8'h79, 1'b1);
    expw(2, 0, 8'h7A, 1'b1);
    wait_idle();
    chk("pre_bs_cur_x", cur_x, 3);
    fifo.push_back(8'h08);
    expw(2, 0, 8'h20, 1'b1);
    wait_idle();
    chk("bs_cur_x", cur_x, 2);
    chk("bs_cur_y", cur_y, 0);

    fifo.push_back(8'h09);
    fifo.push_back(8'h7F);
    fifo.push_back(8'h01);
    fifo.push_back(8'hFF);
    fifo.push_back(8'h0C);
    wait_idle();
    chk("discard_cur_x", cur_x, 2);
    chk("discard_cur_y", cur_y, 0);

    fifo.push_back(8'h0A);
    for (int i = 0; i <= 10; i++) expw(i, 1, 8'h20, 1'b0);
    begin
      int n = 0;
      while (!(vga_we && vga_addr == {20'd0, 7'd10, 5'd1}) && n < 2000) begin
        @(negedge clk);
        n++;
      end
      chk("clear_col10_reached", vga_addr, {20'd0, 7'd10, 5'd1});
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abort_vga_we", vga_we, 0);
    chk("abort_cur_x", cur_x, 0);
    chk("abort_cur_y", cur_y, 0);
    chk("abort_sb_drained", sb.size(), 0);
    do_reset();
    repeat (5) @(negedge clk);
    chk("final_sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule
